// File: rtl/regfile_rw2r1w.sv
// Two-read / one-write register file for the operand-fetch stage.
// Registered reads (one cycle latency), optional zero register, write bypass, read stall, sync clear.
module regfile_rw2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReadEn,
    input  logic [ADDR_W-1:0] ReadAdd0,
    input  logic [ADDR_W-1:0] ReadAdd1,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] WriteAdd,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] Output0,
    output logic [DATA_W-1:0] Output1
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              write_ok;
    logic [DATA_W-1:0] read_val0;
    logic [DATA_W-1:0] read_val1;

    // A write to the hardwired zero register is dropped entirely, so it can never be forwarded either.
    assign write_ok = WriteEn && !((ZERO_REG != 0) && (WriteAdd == '0));

    // NOTE: every variable is given a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        read_val0 = mem[ReadAdd0];
        read_val1 = mem[ReadAdd1];
        if ((BYPASS != 0) && write_ok && (WriteAdd == ReadAdd0)) read_val0 = WriteData;
        if ((BYPASS != 0) && write_ok && (WriteAdd == ReadAdd1)) read_val1 = WriteData;
        if ((ZERO_REG != 0) && (ReadAdd0 == '0)) read_val0 = '0;
        if ((ZERO_REG != 0) && (ReadAdd1 == '0)) read_val1 = '0;
    end

    // NOTE: state uses non-blocking assignments so every read in this edge sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the array itself is cleared here, which forces it into flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            Output0 <= '0;
            Output1 <= '0;
        end else begin
            if (write_ok) mem[WriteAdd] <= WriteData;
            if (ReadEn) begin
                Output0 <= read_val0;
                Output1 <= read_val1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_rw2r1w.sv
// Directed-vector bench for regfile_rw2r1w: default config, no-zero/no-bypass config, and a small 16x8 config.
module tb_regfile_rw2r1w;

    logic        Clk;
    logic        Reset, ReadEn, WriteEn;
    logic [4:0]  ReadAdd0, ReadAdd1, WriteAdd;
    logic [31:0] WriteData;
    logic [31:0] a_out0, a_out1, b_out0, b_out1;

    logic        c_reset, c_read_en, c_write_en;
    logic [2:0]  c_add0, c_add1, c_write_add;
    logic [15:0] c_write_data;
    logic [15:0] c_out0, c_out1;

    int n_cmp = 0;
    int n_err = 0;

    regfile_rw2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .ReadEn(ReadEn), .ReadAdd0(ReadAdd0), .ReadAdd1(ReadAdd1),
        .WriteEn(WriteEn), .WriteAdd(WriteAdd), .WriteData(WriteData),
        .Output0(a_out0), .Output1(a_out1));

    regfile_rw2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .ReadEn(ReadEn), .ReadAdd0(ReadAdd0), .ReadAdd1(ReadAdd1),
        .WriteEn(WriteEn), .WriteAdd(WriteAdd), .WriteData(WriteData),
        .Output0(b_out0), .Output1(b_out1));

    regfile_rw2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .Clk(Clk), .Reset(c_reset), .ReadEn(c_read_en), .ReadAdd0(c_add0), .ReadAdd1(c_add1),
        .WriteEn(c_write_en), .WriteAdd(c_write_add), .WriteData(c_write_data),
        .Output0(c_out0), .Output1(c_out1));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        rst;
        logic        re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] a0, a1, b0, b1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic re, logic [4:0] ra0, logic [4:0] ra1,
                                logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [31:0] a0, logic [31:0] a1, logic [31:0] b0, logic [31:0] b1);
        vec_t v;
        v.rst = rst; v.re = re; v.ra0 = ra0; v.ra1 = ra1;
        v.we = we; v.wa = wa; v.wd = wd;
        v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_ab(input logic rst, input logic re, input logic [4:0] ra0, input logic [4:0] ra1,
                            input logic we, input logic [4:0] wa, input logic [31:0] wd);
        Reset = rst; ReadEn = re; ReadAdd0 = ra0; ReadAdd1 = ra1;
        WriteEn = we; WriteAdd = wa; WriteData = wd;
    endtask

    task automatic check_ab(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] b0, input logic [31:0] b1);
        check({tag, " A.out0"}, a_out0, a0);
        check({tag, " A.out1"}, a_out1, a1);
        check({tag, " B.out0"}, b_out0, b0);
        check({tag, " B.out1"}, b_out1, b1);
    endtask

    logic [15:0] model [8];

    initial begin
        drive_ab(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        c_reset = 1'b1; c_read_en = 1'b0; c_write_en = 1'b0;
        c_add0 = '0; c_add1 = '0; c_write_add = '0; c_write_data = '0;

        // Reset for two edges, then every address reads zero on both configs.
        tick(); check_ab("reset1", 0, 0, 0, 0);
        tick(); check_ab("reset2", 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive_ab(1'b0, 1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);
            tick();
            check_ab($sformatf("postreset rd%0d", i), 0, 0, 0, 0);
        end

        //                  rst   re    ra0    ra1    we    wa     wd             A.out0         A.out1         B.out0         B.out1
        vecs.push_back(mk(1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 5'd7,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 5'd7,  5'd8,  1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  32'h12345678, 32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h12345678, 32'h12345678));
        vecs.push_back(mk(1'b0, 1'b1, 5'd7,  5'd5,  1'b1, 5'd5,  32'h11111111, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 5'd5,  5'd5,  1'b1, 5'd5,  32'h22222222, 32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111));
        vecs.push_back(mk(1'b0, 1'b1, 5'd5,  5'd5,  1'b0, 5'd0,  32'h0,        32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222));
        vecs.push_back(mk(1'b0, 1'b1, 5'd9,  5'd7,  1'b1, 5'd9,  32'hAAAA0000, 32'hAAAA0000, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b1, 5'd9,  5'd7,  1'b0, 5'd0,  32'h0,        32'hAAAA0000, 32'hDEADBEEF, 32'hAAAA0000, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 5'd9,  5'd5,  1'b1, 5'd9,  32'hBBBB0000, 32'hAAAA0000, 32'hDEADBEEF, 32'hAAAA0000, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 5'd3,  5'd0,  1'b0, 5'd0,  32'h0,        32'hAAAA0000, 32'hDEADBEEF, 32'hAAAA0000, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 5'd9,  5'd1,  1'b1, 5'd7,  32'hCCCC0000, 32'hAAAA0000, 32'hDEADBEEF, 32'hAAAA0000, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b1, 5'd9,  5'd7,  1'b0, 5'd0,  32'h0,        32'hBBBB0000, 32'hCCCC0000, 32'hBBBB0000, 32'hCCCC0000));
        vecs.push_back(mk(1'b1, 1'b1, 5'd9,  5'd7,  1'b1, 5'd9,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 5'd9,  5'd7,  1'b1, 5'd7,  32'h13579BDF, 32'h0,        32'h13579BDF, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 5'd7,  5'd5,  1'b0, 5'd0,  32'h0,        32'h13579BDF, 32'h0,        32'h13579BDF, 32'h0));

        foreach (vecs[i]) begin
            drive_ab(vecs[i].rst, vecs[i].re, vecs[i].ra0, vecs[i].ra1, vecs[i].we, vecs[i].wa, vecs[i].wd);
            tick();
            check_ab($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1);
        end

        // Reset priority: fill every register with 0x100+index, then reset on an edge that also writes.
        for (int i = 0; i < 32; i++) begin
            drive_ab(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'h100 + 32'(i));
            tick();
        end
        drive_ab(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        check_ab("filled rd3/rd0", 32'h103, 32'h0, 32'h103, 32'h100);
        drive_ab(1'b1, 1'b1, 5'd3, 5'd31, 1'b1, 5'd3, 32'hFFFFFFFF);
        tick();
        check_ab("reset+write", 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive_ab(1'b0, 1'b1, 5'(i), 5'(i), 1'b0, 5'd0, 32'h0);
            tick();
            check_ab($sformatf("after reset rd%0d", i), 0, 0, 0, 0);
        end
        drive_ab(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);

        // Small config: top address stores independently of its neighbour.
        c_reset = 1'b1; tick();
        c_reset = 1'b0;
        c_write_en = 1'b1; c_write_add = 3'd7; c_write_data = 16'hA5A5; tick();
        c_write_add = 3'd6; c_write_data = 16'h1234; tick();
        c_write_en = 1'b0; c_read_en = 1'b1; c_add0 = 3'd7; c_add1 = 3'd6; tick();
        check("C top addr", 32'(c_out0), 32'h0000A5A5);
        check("C addr6", 32'(c_out1), 32'h00001234);
        for (int i = 0; i < 8; i++) model[i] = 16'h0;
        model[7] = 16'hA5A5;
        model[6] = 16'h1234;

        // Small config: 1000 random edges against a reference model.
        for (int n = 0; n < 1000; n++) begin
            logic        rst, re, we;
            logic [2:0]  ra0, ra1, wa;
            logic [15:0] wd;
            logic        wr_ok;
            logic [15:0] exp0, exp1;
            rst = ($urandom_range(0, 49) == 0);
            re  = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 2) != 0);
            ra0 = 3'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 4) == 0) ? ra0 : 3'($urandom_range(0, 7));
            wa  = ($urandom_range(0, 2) == 0) ? ra0 : 3'($urandom_range(0, 7));
            wd  = 16'($urandom);
            exp0 = c_out0;
            exp1 = c_out1;
            if (rst) begin
                exp0 = 16'h0;
                exp1 = 16'h0;
                for (int i = 0; i < 8; i++) model[i] = 16'h0;
            end else begin
                wr_ok = we && (wa != 3'd0);
                if (re) begin
                    exp0 = (ra0 == 3'd0) ? 16'h0 : (wr_ok && wa == ra0) ? wd : model[ra0];
                    exp1 = (ra1 == 3'd0) ? 16'h0 : (wr_ok && wa == ra1) ? wd : model[ra1];
                end
                if (wr_ok) model[wa] = wd;
            end
            // A held output must keep the value it showed before this edge; captured above from the previous check.
            c_reset = rst; c_read_en = re; c_write_en = we;
            c_add0 = ra0; c_add1 = ra1; c_write_add = wa; c_write_data = wd;
            tick();
            check($sformatf("C rand%0d out0", n), 32'(c_out0), 32'(exp0));
            check($sformatf("C rand%0d out1", n), 32'(c_out1), 32'(exp1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
